// File: rtl/iob_arbiter.sv
// Request arbiter with round-robin or fixed-priority selection and a configurable grant-hold policy.
// Optional forced release after MAX_HOLD cycles when IOB_ARBITER_TIMEOUT_EN is defined.
module iob_arbiter #(
   parameter int    PORTS        = 4,
   parameter string ARB_TYPE     = "ROUND_ROBIN",
   parameter string LSB_PRIORITY = "LOW",
   parameter string BLOCK        = "REQUEST",
   parameter int    MAX_HOLD     = 16
) (
   input  logic                                          clk_i,
   input  logic                                          arst_n_i,
   input  logic [PORTS-1:0]                              request_i,
   input  logic [PORTS-1:0]                              acknowledge_i,
   output logic [PORTS-1:0]                              grant_o,
   output logic                                          grant_valid_o,
   output logic [((PORTS > 1) ? $clog2(PORTS) : 1)-1:0] grant_encoded_o
);

   localparam int EW       = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam bit IS_RR    = (ARB_TYPE == "ROUND_ROBIN");
   localparam bit SCAN_LOW = (LSB_PRIORITY != "HIGH");
   localparam bit BLK_NONE = (BLOCK == "NONE");
   localparam bit BLK_ACK  = (BLOCK == "ACKNOWLEDGE");
   // Pointer reset value leaves the round-robin mask empty, so the first arbitration is plain priority.
   localparam logic [EW-1:0] PTR_RST = SCAN_LOW ? EW'(PORTS - 1) : '0;

   typedef enum logic {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [PORTS-1:0] grant_q, grant_d;
   logic [EW-1:0]    enc_q, enc_d;
   logic [EW-1:0]    ptr_q, ptr_d;
   logic [PORTS-1:0] rr_mask, req_eff, req_masked;
   logic [EW:0]      pick_res;
   logic             holder_req, holder_ack, timeout, release_c, new_grant;

   // Returns {found, index} of the first set bit in the scan direction.
   function automatic logic [EW:0] pick(input logic [PORTS-1:0] req);
      logic [EW:0] r;
      r = '0;
      if (SCAN_LOW) begin
         for (int i = PORTS - 1; i >= 0; i--)
            if (req[i]) r = {1'b1, EW'(i)};
      end else begin
         for (int i = 0; i < PORTS; i++)
            if (req[i]) r = {1'b1, EW'(i)};
      end
      return r;
   endfunction

   always_comb begin
      rr_mask = '0;
      for (int i = 0; i < PORTS; i++)
         rr_mask[i] = SCAN_LOW ? (i > int'(ptr_q)) : (i < int'(ptr_q));
   end

   assign holder_req = |(request_i & grant_q);
   assign holder_ack = |(acknowledge_i & grant_q);

`ifdef IOB_ARBITER_TIMEOUT_EN
   logic [15:0] hold_cnt_q, hold_cnt_d;

   // hold_cnt_q counts completed cycles, so the current cycle is number hold_cnt_q+1.
   assign timeout = (state_q == GRANTED) && (hold_cnt_q == 16'(MAX_HOLD - 1));

   always_comb begin
      hold_cnt_d = '0;
      if (state_d == GRANTED && !new_grant)
         hold_cnt_d = hold_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) hold_cnt_q <= '0;
      else           hold_cnt_q <= hold_cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      enc_d      = enc_q;
      ptr_d      = ptr_q;
      new_grant  = 1'b0;
      release_c  = (state_q == IDLE) || BLK_NONE || timeout ||
                   (BLK_ACK ? holder_ack : !holder_req);
      req_eff    = timeout ? (request_i & ~grant_q) : request_i;
      req_masked = req_eff & rr_mask;
      pick_res   = (IS_RR && (|req_masked)) ? pick(req_masked) : pick(req_eff);

      if (release_c) begin
         if (pick_res[EW]) begin
            state_d   = GRANTED;
            enc_d     = pick_res[EW-1:0];
            grant_d   = PORTS'(1) << enc_d;
            new_grant = (state_q == IDLE) || (enc_d != enc_q);
            if (new_grant) ptr_d = enc_d;
         end else begin
            state_d = IDLE;
            grant_d = '0;
            enc_d   = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         enc_q   <= '0;
         ptr_q   <= PTR_RST;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         enc_q   <= enc_d;
         ptr_q   <= ptr_d;
      end
   end

   assign grant_o         = grant_q;
   assign grant_valid_o   = (state_q == GRANTED);
   assign grant_encoded_o = enc_q;

endmodule

// File: tb/tb_iob_arbiter.sv
// Bench for iob_arbiter: eight configurations share one stimulus; table vectors, corner sequences,
// then random traffic against a queue-free arithmetic reference model.
module tb_iob_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] ack;

   logic [3:0] g [8];
   logic       v [8];
   logic [1:0] e [8];
   logic       g5;
   logic       e5;

   int checks = 0;
   int errors = 0;

   // Configuration of each instance: ports, round-robin, scan-low, block (0 none,1 req,2 ack), max hold
   int c_ports [8] = '{4, 4, 4, 4, 4, 1, 4, 4};
   bit c_rr    [8] = '{1, 0, 0, 1, 1, 1, 1, 1};
   bit c_low   [8] = '{1, 1, 0, 1, 1, 1, 1, 0};
   int c_blk   [8] = '{0, 0, 0, 1, 2, 1, 1, 1};
   int c_max   [8] = '{16, 16, 16, 16, 16, 16, 3, 16};

   // Reference model state
   int holder [8];
   int last   [8];
   int held   [8];
   bit first  [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   iob_arbiter #(.PORTS(4), .ARB_TYPE("ROUND_ROBIN"), .LSB_PRIORITY("LOW"), .BLOCK("NONE")) u0 (
      .clk_i(clk), .arst_n_i(rst_n), .request_i(req), .acknowledge_i(ack),
      .grant_o(g[0]), .grant_valid_o(v[0]), .grant_encoded_o(e[0]));
   iob_arbiter #(.PORTS(4), .ARB_TYPE("PRIORITY"), .LSB_PRIORITY("LOW"), .BLOCK("NONE")) u1 (
      .clk_i(clk), .arst_n_i(rst_n), .request_i(req), .acknowledge_i(ack),
      .grant_o(g[1]), .grant_valid_o(v[1]), .grant_encoded_o(e[1]));
   iob_arbiter #(.PORTS(4), .ARB_TYPE("PRIORITY"), .LSB_PRIORITY("HIGH"), .BLOCK("NONE")) u2 (
      .clk_i(clk), .arst_n_i(rst_n), .request_i(req), .acknowledge_i(ack),
      .grant_o(g[2]), .grant_valid_o(v[2]), .grant_encoded_o(e[2]));
   iob_arbiter #(.PORTS(4), .ARB_TYPE("ROUND_ROBIN"), .LSB_PRIORITY("LOW"), .BLOCK("REQUEST")) u3 (
      .clk_i(clk), .arst_n_i(rst_n), .request_i(req), .acknowledge_i(ack),
      .grant_o(g[3]), .grant_valid_o(v[3]), .grant_encoded_o(e[3]));
   iob_arbiter #(.PORTS(4), .ARB_TYPE("ROUND_ROBIN"), .LSB_PRIORITY("LOW"), .BLOCK("ACKNOWLEDGE")) u4 (
      .clk_i(clk), .arst_n_i(rst_n), .request_i(req), .acknowledge_i(ack),
      .grant_o(g[4]), .grant_valid_o(v[4]), .grant_encoded_o(e[4]));
   iob_arbiter #(.PORTS(1), .ARB_TYPE("ROUND_ROBIN"), .LSB_PRIORITY("LOW"), .BLOCK("REQUEST")) u5 (
      .clk_i(clk), .arst_n_i(rst_n), .request_i(req[0]), .acknowledge_i(ack[0]),
      .grant_o(g5), .grant_valid_o(v[5]), .grant_encoded_o(e5));
   iob_arbiter #(.PORTS(4), .ARB_TYPE("ROUND_ROBIN"), .LSB_PRIORITY("LOW"), .BLOCK("REQUEST"),
                 .MAX_HOLD(3)) u6 (
      .clk_i(clk), .arst_n_i(rst_n), .request_i(req), .acknowledge_i(ack),
      .grant_o(g[6]), .grant_valid_o(v[6]), .grant_encoded_o(e[6]));
   iob_arbiter #(.PORTS(4), .ARB_TYPE("ROUND_ROBIN"), .LSB_PRIORITY("HIGH"), .BLOCK("REQUEST")) u7 (
      .clk_i(clk), .arst_n_i(rst_n), .request_i(req), .acknowledge_i(ack),
      .grant_o(g[7]), .grant_valid_o(v[7]), .grant_encoded_o(e[7]));

   assign g[5] = {3'b000, g5};
   assign e[5] = {1'b0, e5};

   typedef struct {
      logic [3:0] req;
      logic [3:0] exp_rr;
      logic [3:0] exp_lo;
      logic [3:0] exp_hi;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [3:0] oh);
      for (int i = 0; i < 4; i++)
         if (oh[i]) return i;
      return 0;
   endfunction

   task automatic chk_grant(input string name, input int c, input logic [3:0] exp_g);
      chk({name, " grant"}, int'(g[c]), int'(exp_g));
      chk({name, " valid"}, int'(v[c]), int'(|exp_g));
      chk({name, " enc"},   int'(e[c]), idx_of(exp_g));
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset;
      for (int c = 0; c < 8; c++) begin
         holder[c] = -1;
         last[c]   = 0;
         held[c]   = 0;
         first[c]  = 1'b1;
      end
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      ack   = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Winner by the rules: plain scan, or first requester strictly after the last grant with wrap-around.
   function automatic int pick(input int p, input bit rr, input bit low, input int lst,
                               input bit fst, input logic [3:0] r);
      int idx;
      if (!rr || fst) begin
         for (int k = 0; k < p; k++) begin
            idx = low ? k : p - 1 - k;
            if (r[idx]) return idx;
         end
      end else begin
         for (int k = 1; k <= p; k++) begin
            idx = low ? (lst + k) % p : (lst - k + p) % p;
            if (r[idx]) return idx;
         end
      end
      return -1;
   endfunction

   task automatic model_step(input int c, input logic [3:0] r_in, input logic [3:0] a_in);
      logic [3:0] pm, r, cand;
      int         h, w;
      bit         to, rel;
      pm = (c_ports[c] == 4) ? 4'hF : 4'h1;
      r  = r_in & pm;
      h  = holder[c];
      to = 1'b0;
`ifdef IOB_ARBITER_TIMEOUT_EN
      to = (h >= 0) && (held[c] >= c_max[c]);
`endif
      if (h < 0) rel = 1'b1;
      else rel = (c_blk[c] == 0) || to || (c_blk[c] == 1 && !r[h]) || (c_blk[c] == 2 && a_in[h]);
      if (!rel) begin
         held[c]++;
      end else begin
         cand = r;
         if (to) cand[h] = 1'b0;
         w = pick(c_ports[c], c_rr[c], c_low[c], last[c], first[c], cand);
         if (w < 0) begin
            holder[c] = -1;
            held[c]   = 0;
         end else begin
            held[c]   = (w == h) ? held[c] + 1 : 1;
            holder[c] = w;
            last[c]   = w;
            first[c]  = 1'b0;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      req   = '0;
      ack   = '0;

      // Round-robin (u0), priority low (u1), priority high (u2), all BLOCK=NONE
      for (int i = 0; i < 8; i++) begin
         vecs[i].req    = 4'b1111;
         vecs[i].exp_rr = 4'b0001 << (i % 4);
         vecs[i].exp_lo = 4'b0001;
         vecs[i].exp_hi = 4'b1000;
      end
      vecs[8]  = '{4'b1010, 4'b0010, 4'b0010, 4'b1000};
      vecs[9]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vecs[10] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100};
      vecs[11] = '{4'b1001, 4'b1000, 4'b0001, 4'b1000};

      @(negedge clk);
      chk_grant("reset u0", 0, 4'b0000);
      chk_grant("reset u4", 4, 4'b0000);
      do_reset();
      for (int i = 0; i < 12; i++) begin
         req = vecs[i].req;
         tick();
         chk_grant($sformatf("vec%0d rr", i), 0, vecs[i].exp_rr);
         chk_grant($sformatf("vec%0d prio_low", i), 1, vecs[i].exp_lo);
         chk_grant($sformatf("vec%0d prio_high", i), 2, vecs[i].exp_hi);
      end

      // Request hold: holder 2 drops while 0 and 3 wait, port 3 follows with no bubble
      do_reset();
      req = 4'b0100;
      tick();
      chk_grant("req_hold first", 3, 4'b0100);
      req = 4'b1101;
      tick();
      chk_grant("req_hold held", 3, 4'b0100);
      req = 4'b1001;
      tick();
      chk_grant("req_hold handover", 3, 4'b1000);

      // Acknowledge hold: request drop and foreign ack ignored, own ack releases
      do_reset();
      req = 4'b0010;
      tick();
      chk_grant("ack_hold first", 4, 4'b0010);
      req = 4'b0000;
      tick();
      chk_grant("ack_hold req_drop", 4, 4'b0010);
      ack = 4'b0001;
      tick();
      chk_grant("ack_hold foreign_ack", 4, 4'b0010);
      ack = 4'b0010;
      tick();
      chk_grant("ack_hold release", 4, 4'b0000);
      ack = 4'b0000;

      // Single port follows request hold
      req = 4'b0001;
      tick();
      chk_grant("p1 grant", 5, 4'b0001);
      req = 4'b0000;
      tick();
      chk_grant("p1 release", 5, 4'b0000);

      // Asynchronous reset in the middle of a grant
      do_reset();
      req = 4'b1111;
      tick();
      tick();
      chk_grant("areset before", 0, 4'b0010);
      #1;
      rst_n = 1'b0;
      #1;
      chk_grant("areset async u0", 0, 4'b0000);
      chk_grant("areset async u3", 3, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk_grant("areset first rr", 0, 4'b0001);
      chk_grant("areset first high", 2, 4'b1000);

`ifdef IOB_ARBITER_TIMEOUT_EN
      // Forced release after MAX_HOLD=3 cycles on u6; u3 (MAX_HOLD=16) keeps holding
      do_reset();
      req = 4'b0011;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_grant($sformatf("timeout hold%0d", i), 6, 4'b0001);
      end
      tick();
      chk_grant("timeout switch", 6, 4'b0010);
      chk_grant("timeout long_hold", 3, 4'b0001);
`endif

      // Random traffic against the reference model
      do_reset();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 1) == 0) req = 4'($urandom_range(0, 15));
         ack = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         for (int c = 0; c < 8; c++) model_step(c, req, ack);
         tick();
         for (int c = 0; c < 8; c++)
            chk_grant($sformatf("rand%0d c%0d", n, c), c,
                      (holder[c] >= 0) ? (4'b0001 << holder[c]) : 4'b0000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
